// File: rtl/tc_clk_gate_ctrl_pkg.sv
// Shared types and helpers for the clock-gate controller.
package tc_clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } gate_state_e;

  // Width of a counter that must hold values up to max(idle, wake) without wrapping.
  function automatic int cnt_width(input int idle, input int wake);
    int m;
    m = (idle > wake) ? idle : wake;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tc_clk_gate_stat_cnt.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module tc_clk_gate_stat_cnt #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/tc_clk_gate_ctrl.sv
// Idle-driven enable generator for a clock gating cell with req/gnt wake handshake
// and gated-cycle telemetry. Runs on the ungated source clock.
module tc_clk_gate_ctrl
  import tc_clk_gate_ctrl_pkg::*;
#(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2,
  parameter int StatWidth  = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 force_on_i,
  input  logic                 busy_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  output logic                 clk_en_o,
  output logic                 gated_o,
  input  logic                 stat_clr_i,
  output logic [StatWidth-1:0] gated_cycles_o
);

  localparam int CntW = cnt_width(IdleCycles, WakeCycles);
  localparam logic [CntW-1:0] IdleLast = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] WakeLast = CntW'((WakeCycles > 0) ? (WakeCycles - 1) : 0);

  if (IdleCycles < 1) begin : g_bad_idle
    $error("tc_clk_gate_ctrl: IdleCycles must be >= 1");
  end
  if (WakeCycles < 0) begin : g_bad_wake
    $error("tc_clk_gate_ctrl: WakeCycles must be >= 0");
  end

  gate_state_e     r_state;
  gate_state_e     w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic            w_idle;
  logic            r_clk_en;
  logic            r_gnt;
  logic            r_gated;

  always_comb begin
    w_idle      = enable_i & ~force_on_i & ~busy_i & ~req_i;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (!w_idle) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == IdleLast) begin
          w_state_nxt = GATED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GATED: begin
        if (!w_idle) begin
          w_state_nxt = (WakeCycles == 0) ? RUN : WAKE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      WAKE: begin
        // No abort path: a started wake always completes so gnt_o timing stays fixed.
        if (r_cnt == WakeLast) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they settle with the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_clk_en <= 1'b1;
      r_gnt    <= 1'b1;
      r_gated  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clk_en <= (w_state_nxt != GATED);
      r_gnt    <= (w_state_nxt == RUN);
      r_gated  <= (w_state_nxt == GATED);
    end
  end

  assign clk_en_o = r_clk_en;
  assign gnt_o    = r_gnt;
  assign gated_o  = r_gated;

  tc_clk_gate_stat_cnt #(
    .Width (StatWidth)
  ) u_stat_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (stat_clr_i),
    .inc_i  (r_state == GATED),
    .cnt_o  (gated_cycles_o)
  );

endmodule
